// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_RW byte-writable control registers followed by
// NUM_RO read-only status words, with SLVERR for RO/unmapped writes and unmapped reads.
module axi4_lite_reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_RW     = 4,
    parameter int                    NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RW_RESET   = '0
) (
    input  logic                                          ACLK,
    input  logic                                          ARESETN,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                       S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                         S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                  rw_regs,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] ro_regs,
    output logic [NUM_RW-1:0]                             wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Holds READY low until the first clock after reset release.
    logic rdy_en_q;

    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
    logic [DATA_WIDTH-1:0] rw_d [NUM_RW];
    logic [NUM_RW-1:0]     wr_pulse_c;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] aw_idx_ext, ar_idx_ext;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign S_AXI_AWREADY = rdy_en_q & ~aw_full_q & ~bvalid_q;
    assign S_AXI_WREADY  = rdy_en_q & ~w_full_q & ~bvalid_q;
    assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign wr_pulse      = wr_pulse_c;

    assign aw_hs      = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs       = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs      = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit     = aw_full_q & w_full_q;
    assign aw_idx_ext = 32'(aw_idx_q);
    assign ar_idx_ext = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

    generate
        for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw_out
            assign rw_regs[gi*DATA_WIDTH +: DATA_WIDTH] = rw_q[gi];
        end
    endgenerate

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        wr_pulse_c = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            rw_d[k] = rw_q[k];
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        // Buffers cannot refill while BVALID is high, so commit and B completion never overlap.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            for (int k = 0; k < NUM_RW; k++) begin
                if (aw_idx_ext == 32'(k)) begin
                    bresp_d       = RESP_OKAY;
                    wr_pulse_c[k] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            rw_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Reads see rw_q before any same-cycle commit, i.e. the pre-write value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (ar_idx_ext == 32'(k)) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = rw_q[k];
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (ar_idx_ext == 32'(NUM_RW + j)) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = ro_regs[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_en_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                rw_q[k] <= RW_RESET;
            end
        end else begin
            rdy_en_q  <= 1'b1;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            for (int k = 0; k < NUM_RW; k++) begin
                rw_q[k] <= rw_d[k];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed bench for axi4_lite_reg_bank: one task per scenario, inline comparisons,
// one summary line at the end.
module tb_axi4_lite_reg_bank;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0;
    logic [2:0]    S_AXI_AWPROT = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AW-1:0] S_AXI_ARADDR = '0;
    logic [2:0]    S_AXI_ARPROT = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;
    logic [127:0]  rw_regs;
    logic [127:0]  ro_regs = '0;
    logic [3:0]    wr_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    axi4_lite_reg_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_RW(4), .NUM_RO(4), .RW_RESET(32'h0)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .rw_regs(rw_regs), .ro_regs(ro_regs), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Bus driver: AW and W presented together; returns observations for the caller to check.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse_commit,
                             output logic [3:0] pulse_after, output logic bv_late);
        int n;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) begin
            tests_run++; tests_failed++;
            $display("FAIL wr_accept_timeout: got no AW/W ready, required ready within 20 cycles");
        end
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        pulse_commit = wr_pulse;
        @(posedge ACLK); #1;
        pulse_after = wr_pulse;
        bv_late = !S_AXI_BVALID;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) begin
            tests_run++; tests_failed++;
            $display("FAIL bvalid_timeout: got no BVALID, required BVALID within 20 cycles");
        end
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        $display("[TB] write addr=%02h data=%08h strb=%h bresp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic rv_late);
        int n;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) begin
            tests_run++; tests_failed++;
            $display("FAIL rd_accept_timeout: got no ARREADY, required ready within 20 cycles");
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        rv_late = !S_AXI_RVALID;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            @(posedge ACLK); #1; n++;
        end
        if (n >= 20) begin
            tests_run++; tests_failed++;
            $display("FAIL rvalid_timeout: got no RVALID, required RVALID within 20 cycles");
        end
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        $display("[TB] read  addr=%02h data=%08h rresp=%0d", addr, data, resp);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #12;
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b, required 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        tests_run++;
        if (rw_regs !== 128'h0 || wr_pulse !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got rw=%h pulse=%h, required 0/0", rw_regs, wr_pulse);
        end
        tests_run++;
        if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'h0 || S_AXI_RDATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_resp: got bresp=%0d rresp=%0d rdata=%h, required 0/0/0",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, required 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        $display("[TB] reset released");
    endtask

    task automatic test_write_read();
        logic [31:0] vals [4];
        logic [31:0] rd;
        logic [1:0]  resp, rresp;
        logic [3:0]  pc, pa, exp_p;
        logic        late, rlate;
        vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
        vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
        for (int k = 0; k < 4; k++) begin
            exp_p = 4'(1 << k);
            axi_write(8'(k * 4), vals[k], 4'hF, resp, pc, pa, late);
            tests_run++;
            if (resp !== 2'b00 || late !== 1'b0) begin
                tests_failed++;
                $display("FAIL wr%0d_bresp: got bresp=%0d late=%b, required 0/0", k, resp, late);
            end
            tests_run++;
            if (pc !== exp_p || pa !== 4'h0) begin
                tests_failed++;
                $display("FAIL wr%0d_pulse: got commit=%b after=%b, required %b/0000", k, pc, pa, exp_p);
            end
            tests_run++;
            if (rw_regs[k*32 +: 32] !== vals[k]) begin
                tests_failed++;
                $display("FAIL wr%0d_rwregs: got %h, required %h", k, rw_regs[k*32 +: 32], vals[k]);
            end
            axi_read(8'(k * 4), rd, rresp, rlate);
            tests_run++;
            if (rd !== vals[k] || rresp !== 2'b00 || rlate !== 1'b0) begin
                tests_failed++;
                $display("FAIL rd%0d_data: got %h resp=%0d late=%b, required %h/0/0",
                         k, rd, rresp, rlate, vals[k]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic [1:0]  resp, rresp;
        logic [3:0]  pc, pa;
        logic        late, rlate;
        axi_write(8'h04, 32'h12345678, 4'b0101, resp, pc, pa, late);
        axi_read(8'h04, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'hAB340078 || resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL strobe_merge: got %h bresp=%0d, required ab340078/0", rd, resp);
        end
        axi_write(8'h04, 32'hFFFFFFFF, 4'b0000, resp, pc, pa, late);
        tests_run++;
        if (resp !== 2'b00 || pc !== 4'b0010 || rw_regs[63:32] !== 32'hAB340078) begin
            tests_failed++;
            $display("FAIL strobe_zero: got bresp=%0d pulse=%b reg=%h, required 0/0010/ab340078",
                     resp, pc, rw_regs[63:32]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] rd;
        logic [1:0]  rresp;
        logic        rlate;
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        tests_run++;
        if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL wfirst_ready: got wready=%b awready=%b, required 0/1",
                     S_AXI_WREADY, S_AXI_AWREADY);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge ACLK); #1;
        end
        tests_run++;
        if (wr_pulse !== 4'h0 || S_AXI_BVALID !== 1'b0 || rw_regs[95:64] !== 32'hDEAD0011) begin
            tests_failed++;
            $display("FAIL wfirst_wait: got pulse=%b bvalid=%b reg=%h, required 0000/0/dead0011",
                     wr_pulse, S_AXI_BVALID, rw_regs[95:64]);
        end
        S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        tests_run++;
        if (wr_pulse !== 4'b0100 || S_AXI_BVALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL wfirst_commit: got pulse=%b bvalid=%b, required 0100/0", wr_pulse, S_AXI_BVALID);
        end
        @(posedge ACLK); #1;
        tests_run++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || rw_regs[95:64] !== 32'h55AA55AA) begin
            tests_failed++;
            $display("FAIL wfirst_bvalid: got bvalid=%b bresp=%0d reg=%h, required 1/0/55aa55aa",
                     S_AXI_BVALID, S_AXI_BRESP, rw_regs[95:64]);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        $display("[TB] write addr=08 data=55aa55aa (W before AW)");
        axi_read(8'h08, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'h55AA55AA || rresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL wfirst_readback: got %h/%0d, required 55aa55aa/0", rd, rresp);
        end
    endtask

    task automatic test_ro_unmapped();
        logic [31:0]  rd;
        logic [1:0]   resp, rresp;
        logic [3:0]   pc, pa;
        logic         late, rlate;
        logic [127:0] snap;
        ro_regs = {32'h44444444, 32'h33333333, 32'h22222222, 32'hCAFE0001};
        axi_read(8'h10, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'hCAFE0001 || rresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL ro0_read: got %h/%0d, required cafe0001/0", rd, rresp);
        end
        axi_read(8'h1C, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'h44444444 || rresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL ro3_read: got %h/%0d, required 44444444/0", rd, rresp);
        end
        snap = {32'hBEEF0011, 32'h55AA55AA, 32'hAB340078, 32'h0101FFFF};
        axi_write(8'h10, 32'h0BADF00D, 4'hF, resp, pc, pa, late);
        tests_run++;
        if (resp !== 2'b10 || pc !== 4'h0 || rw_regs !== snap) begin
            tests_failed++;
            $display("FAIL ro_write: got bresp=%0d pulse=%b rw=%h, required 2/0000/%h", resp, pc, rw_regs, snap);
        end
        axi_write(8'h40, 32'h0BADF00D, 4'hF, resp, pc, pa, late);
        tests_run++;
        if (resp !== 2'b10 || pc !== 4'h0 || rw_regs !== snap) begin
            tests_failed++;
            $display("FAIL unmapped_write: got bresp=%0d pulse=%b, required 2/0000", resp, pc);
        end
        axi_read(8'h40, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'h0 || rresp !== 2'b10) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h/%0d, required 00000000/2", rd, rresp);
        end
        axi_read(8'h20, rd, rresp, rlate);
        tests_run++;
        if (rd !== 32'h0 || rresp !== 2'b10) begin
            tests_failed++;
            $display("FAIL first_unmapped_read: got %h/%0d, required 00000000/2", rd, rresp);
        end
    endtask

    task automatic test_stall_and_reset();
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h600D600D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        tests_run++;
        if (rw_regs[127:96] !== 32'h600D600D) begin
            tests_failed++;
            $display("FAIL stall_write: got %h, required 600d600d", rw_regs[127:96]);
        end
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hAB340078 ||
                S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got bv=%b rv=%b rdata=%h rresp=%0d bresp=%0d, required 1/1/ab340078/0/0",
                         i, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP);
            end
            tests_run++;
            if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
                tests_failed++;
                $display("FAIL stall_ready%0d: got %b, required 000", i,
                         {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
            end
            if (i < 4) begin
                @(posedge ACLK); #1;
            end
        end
        #2;
        ARESETN = 1'b0;
        #1;
        tests_run++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || rw_regs !== 128'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got bv=%b rv=%b rw=%h, required 0/0/0", S_AXI_BVALID, S_AXI_RVALID, rw_regs);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        $display("[TB] reset pulsed during stalled responses");
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            tests_run++;
            if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort%0d: got bv=%b rv=%b, required 0/0", i, S_AXI_BVALID, S_AXI_RVALID);
            end
        end
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111 || rw_regs !== 128'h0) begin
            tests_failed++;
            $display("FAIL post_reset: got ready=%b rw=%h, required 111/0",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, rw_regs);
        end
    endtask

    task automatic test_read_during_commit();
        logic [1:0] resp;
        logic [3:0] pc, pa;
        logic       late;
        axi_write(8'h00, 32'h00001234, 4'hF, resp, pc, pa, late);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hFFFF0000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        tests_run++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00001234 || S_AXI_BVALID !== 1'b1 ||
            rw_regs[31:0] !== 32'hFFFF0000) begin
            tests_failed++;
            $display("FAIL read_during_commit: got rv=%b rdata=%h bv=%b reg=%h, required 1/00001234/1/ffff0000",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, rw_regs[31:0]);
        end
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        $display("[TB] read addr=00 data=%08h during commit of ffff0000", 32'h00001234);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_w_before_aw();
        test_ro_unmapped();
        test_stall_and_reset();
        test_read_during_commit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_bank.md
Name: axi4_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank; next generation of the fixed 4-register S00_AXI slave used by our ADC interface IP cores.
- Provides NUM_RW configurable read/write control registers and NUM_RO read-only status registers.
- Supports per-byte write strobes, independent AW/W acceptance, SLVERR on illegal accesses, and per-register write pulses.
- Sits between the PS AXI interconnect and IP core datapaths (e.g. ADC LVDS capture).

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64.
ADDR_WIDTH, 8, AXI address width; byte addressed.
NUM_RW, 4, number of read/write registers; 1..32.
NUM_RO, 4, number of read-only status registers; 0..32.
RW_RESET, 0, reset value applied to every RW register.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
S_AXI_ARADDR  in  ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
rw_regs  out  NUM_RW*DATA_WIDTH  RW register contents; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
ro_regs  in  max(NUM_RO,1)*DATA_WIDTH  status inputs; same packing.
wr_pulse  out  NUM_RW  one-cycle strobe when register k is written.

Behaviour:
Reset (asynchronous, ARESETN low):
- All READY and VALID outputs are 0; BRESP, RRESP, RDATA and wr_pulse are 0.
- Every RW register takes RW_RESET.
- Reset assertion mid-transaction aborts it; no response is issued afterwards.

Address decode:
- Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
- Index 0..NUM_RW-1 addresses the RW registers.
- Index NUM_RW..NUM_RW+NUM_RO-1 addresses the RO registers.
- Any other index is unmapped.

Write channel:
- AWREADY and WREADY are each 1 while their own holding buffer is empty and BVALID is 0. AW and W are accepted independently, in either order or in the same cycle.
- Commit happens in the first cycle both buffers are full:
  - RW target: only bytes with a set WSTRB bit are updated; wr_pulse[k] = 1 for that single cycle; BRESP=OKAY.
  - RO or unmapped target: no state change; BRESP=SLVERR (2'b10).
- BVALID rises the cycle after commit and holds until BREADY; both buffers clear on commit.
- Minimum latency, AW and W together: commit 1 cycle after acceptance, BVALID 2 cycles after acceptance.
- WSTRB=0 to an RW register: OKAY, no data change, wr_pulse still asserted.

Read channel:
- ARREADY = 1 while RVALID is 0.
- On the AR handshake, data is captured and RVALID rises next cycle:
  - RW register: current value.
  - RO register: ro_regs sampled in the handshake cycle.
  - Unmapped: RDATA = 0, RRESP = SLVERR.
- RDATA and RRESP stay stable while RVALID=1 and RREADY=0.
- Back-to-back reads sustain one read per 2 cycles.

Simultaneous events:
- A read handshake in the same cycle as a write commit to the same RW register returns the pre-write value.
- Read and write channels are fully independent; neither stalls the other.

Test Plan:
1. Reset with NUM_RW=4, RW_RESET=0 -> all rw_regs=0, all VALID/READY=0 during reset; AWREADY=WREADY=ARREADY=1 one cycle after release.
2. Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00, 0x04, 0x08, 0x0C, each followed by a read-back -> data matches, BRESP=RRESP=OKAY, wr_pulse one cycle per write.
3. Register 0x04 = 0xABCD0001, then write 0x12345678 with WSTRB=4'b0101 -> read-back 0xAB340078.
4. W presented 3 cycles before AW to 0x08 with value 0x55AA55AA -> W accepted first; commit in the cycle AW is captured; BVALID the cycle after; value stored.
5. ro_regs[0] = 0xCAFE0001; read 0x10 -> 0xCAFE0001, OKAY. Write to 0x10 -> SLVERR, no change. Read 0x40 (unmapped) -> RDATA=0, SLVERR.
6. BREADY and RREADY held low 5 cycles -> BVALID, RVALID and RDATA stable; no new AW/AR accepted. ARESETN pulsed low mid-hold -> all VALIDs drop asynchronously and registers return to RW_RESET.
